// File: rtl/add_operand_stage.sv
// rtl/add_operand_stage.sv - paired operand FIFOs feeding a combinational adder, registered result stream
// Optional feature: define ADD_OPERAND_CARRY_EN to add the registered res_carry output.
module add_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [DATA_WIDTH-1:0]      a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [DATA_WIDTH-1:0]      b_data,
    output logic [DATA_WIDTH-1:0]      add_a,
    output logic [DATA_WIDTH-1:0]      add_b,
    input  logic [DATA_WIDTH-1:0]      add_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [$clog2(DEPTH):0]     a_level,
    output logic [$clog2(DEPTH):0]     b_level
`ifdef ADD_OPERAND_CARRY_EN
    ,
    output logic                       res_carry
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] a_mem [DEPTH];
    logic [DATA_WIDTH-1:0] b_mem [DEPTH];
    logic [PW-1:0]         a_wr, a_rd, b_wr, b_rd;
    logic                  a_full, a_empty, b_full, b_empty;
    logic                  a_push, b_push, fire;

    // The extra pointer bit distinguishes full from empty when the index bits match.
    assign a_full  = (a_wr[AW] != a_rd[AW]) && (a_wr[AW-1:0] == a_rd[AW-1:0]);
    assign b_full  = (b_wr[AW] != b_rd[AW]) && (b_wr[AW-1:0] == b_rd[AW-1:0]);
    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);

    assign a_ready = !a_full && rst_n;
    assign b_ready = !b_full && rst_n;
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;
    assign fire    = !a_empty && !b_empty && (!res_valid || res_ready);

    assign add_a   = a_mem[a_rd[AW-1:0]];
    assign add_b   = b_mem[b_rd[AW-1:0]];
    assign a_level = a_wr - a_rd;
    assign b_level = b_wr - b_rd;

    always_ff @(posedge clk) begin
        if (a_push) a_mem[a_wr[AW-1:0]] <= a_data;
        if (b_push) b_mem[b_wr[AW-1:0]] <= b_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wr <= '0;
            a_rd <= '0;
            b_wr <= '0;
            b_rd <= '0;
        end else begin
            if (a_push) a_wr <= a_wr + 1'b1;
            if (b_push) b_wr <= b_wr + 1'b1;
            if (fire) begin
                a_rd <= a_rd + 1'b1;
                b_rd <= b_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (fire) begin
            res_valid <= 1'b1;
            res_data  <= add_result;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ADD_OPERAND_CARRY_EN
    logic [DATA_WIDTH:0] carry_sum;
    assign carry_sum = {1'b0, add_a} + {1'b0, add_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    res_carry <= 1'b0;
        else if (fire) res_carry <= carry_sum[DATA_WIDTH];
    end
`endif

endmodule

// File: tb/tb_add_operand_stage.sv
// tb/tb_add_operand_stage.sv - scoreboard bench for add_operand_stage
module tb_add_operand_stage;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int NRAND = 10000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, res_ready = 1'b0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, res_valid;
    logic [DW-1:0] add_a, add_b, add_result, res_data;
    logic [LW-1:0] a_level, b_level;
`ifdef ADD_OPERAND_CARRY_EN
    logic          res_carry;
`endif

    always #5 clk = ~clk;

    // Stand-in for the external combinational adder.
    assign add_result = add_a + add_b;

    add_operand_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .a_level(a_level), .b_level(b_level)
`ifdef ADD_OPERAND_CARRY_EN
        , .res_carry(res_carry)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];
    logic [DW:0]   exp_q[$];
    logic          mdl_valid = 1'b0;
    bit            mon_en = 1'b0;
    int            a_acc = 0, b_acc = 0, pops = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic       mfire;
            logic [DW:0] e;
            chk("res_valid", res_valid, mdl_valid);
            chk("a_ready", a_ready, a_q.size() < DEPTH);
            chk("b_ready", b_ready, b_q.size() < DEPTH);
            chk("a_level", a_level, a_q.size());
            chk("b_level", b_level, b_q.size());
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk("spurious_result", 1'b1, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    chk("res_data", res_data, e[DW-1:0]);
`ifdef ADD_OPERAND_CARRY_EN
                    chk("res_carry", res_carry, e[DW]);
`endif
                end
            end
            mfire = (a_q.size() > 0) && (b_q.size() > 0) && (!mdl_valid || res_ready);
            if (mfire) begin
                chk("head_a", add_a, a_q[0]);
                chk("head_b", add_b, b_q[0]);
                exp_q.push_back({1'b0, a_q[0]} + {1'b0, b_q[0]});
                void'(a_q.pop_front());
                void'(b_q.pop_front());
                pops++;
                mdl_valid = 1'b1;
            end else if (mdl_valid && res_ready) begin
                mdl_valid = 1'b0;
            end
            if (a_valid && a_ready) begin a_q.push_back(a_data); a_acc++; end
            if (b_valid && b_ready) begin b_q.push_back(b_data); b_acc++; end
        end
    end

    task automatic send(input logic va, input logic [DW-1:0] da, input logic vb, input logic [DW-1:0] db);
        a_valid = va; a_data = da;
        b_valid = vb; b_data = db;
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        res_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || mdl_valid || (a_q.size() != 0 && b_q.size() != 0)) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_timeout", t < 500, 1'b1);
    endtask

    task automatic clear_model();
        a_q.delete(); b_q.delete(); exp_q.delete();
        mdl_valid = 1'b0;
    endtask

    initial begin
        int a0, b0, cyc;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_a_level", a_level, 0);
        chk("rst_b_level", b_level, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_after_rst", {a_ready, b_ready}, 2'b11);
        mon_en = 1'b1;
        res_ready = 1'b1;

        // single pair: valid exactly one cycle, two edges after presenting
        send(1, 5, 1, 7);
        @(posedge clk); #1;
        chk("pair_valid", res_valid, 1);
        chk("pair_data", res_data, 12);
        @(posedge clk); #1;
        chk("pair_valid_drop", res_valid, 0);

        send(1, 32'hFFFF_FFFF, 1, 32'h0000_0002);
        @(posedge clk); #1;
        chk("wrap_data", res_data, 32'h1);
`ifdef ADD_OPERAND_CARRY_EN
        chk("wrap_carry", res_carry, 1);
`endif
        drain();

        // skewed streams
        for (int i = 1; i <= 4; i++) send(1, i, 0, 0);
        chk("skew_a_level", a_level, 4);
        chk("skew_a_ready", a_ready, 0);
        chk("skew_res_valid", res_valid, 0);
        for (int i = 1; i <= 4; i++) send(0, 0, 1, 10 * i);
        drain();

        // backpressure
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send(1, 100 + i, 1, 200 + i);
        @(posedge clk); #1;
        chk("bp_res_data", res_data, 300);
        chk("bp_a_level", a_level, DEPTH);
        chk("bp_b_level", b_level, DEPTH);
        chk("bp_readies", {a_ready, b_ready}, 2'b00);
        drain();

        // mid-operation reset
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 7 + i, 1, 9 + i);
        chk("mr_a_level", a_level, 3);
        chk("mr_b_level", b_level, 3);
        chk("mr_res_valid", res_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        chk("mr_rst_res_valid", res_valid, 0);
        chk("mr_rst_res_data", res_data, 0);
        chk("mr_rst_levels", {a_level, b_level}, 0);
        chk("mr_rst_readies", {a_ready, b_ready}, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;
        res_ready = 1'b1;
        send(1, 1, 1, 1);
        @(posedge clk); #1;
        chk("mr_fresh_data", res_data, 2);
        drain();

        // long random run
        a0 = a_acc; b0 = b_acc; cyc = 0;
        while ((a_acc - a0 < NRAND || b_acc - b0 < NRAND) && cyc < 60000) begin
            a_valid   = (a_acc - a0 < NRAND) && ($urandom_range(7) != 0);
            b_valid   = (b_acc - b0 < NRAND) && ($urandom_range(7) != 0);
            a_data    = $urandom;
            b_data    = $urandom;
            res_ready = ($urandom_range(3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("rand_timeout", cyc < 60000, 1'b1);
        drain();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("wrap_exercised", pops > 1000 * DEPTH, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_operand_stage.md
# add_operand_stage

Upstream feeder for the combinational `adder`. It accepts `src1` and `src2` operands on two independent valid/ready streams and buffers each stream in its own FIFO. When both FIFOs hold an operand, it pops them as a pair and drives them onto the adder inputs. It registers the adder's result onto a valid/ready output stream, so the combinational adder becomes a flow-controlled, pipelined arithmetic stage.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: operand and result width; matches the adder.
- `DEPTH`, default 4: entries per operand FIFO; power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `a_valid`, input, 1: `src1` operand offered.
- `a_ready`, output, 1: `src1` FIFO can accept.
- `a_data`, input, DATA_WIDTH: `src1` operand.
- `b_valid`, input, 1: `src2` operand offered.
- `b_ready`, output, 1: `src2` FIFO can accept.
- `b_data`, input, DATA_WIDTH: `src2` operand.
- `add_a`, output, DATA_WIDTH: head of the `src1` FIFO; connects to `adder.a`.
- `add_b`, output, DATA_WIDTH: head of the `src2` FIFO; connects to `adder.b`.
- `add_result`, input, DATA_WIDTH: combinational result from `adder.result`.
- `res_valid`, output, 1: registered result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_data`, output, DATA_WIDTH: registered sum.
- `a_level`, output, $clog2(DEPTH)+1: `src1` FIFO occupancy.
- `b_level`, output, $clog2(DEPTH)+1: `src2` FIFO occupancy.
- `res_carry`, output, 1: carry-out of the registered sum. Present only with `ADD_OPERAND_CARRY_EN`.

## Operation

- **Operand push:** each FIFO pushes when `x_valid && x_ready`.
  - `x_ready = !full && rst_n`, so it is 0 while reset is asserted.
- **Heads:** `add_a` and `add_b` always show the current FIFO heads. The value on an empty FIFO is don't-care; the bench checks the heads only when `fire` is high.
- **Fire:** `fire = !a_empty && !b_empty && (!res_valid || res_ready)`.
  - On fire, both FIFOs pop, `res_data <= add_result`, and `res_valid <= 1`.
- **Drain:** when `res_valid && res_ready && !fire`, `res_valid <= 0`. `res_data` holds its value.
- **Stall:** while `res_valid && !res_ready`, `res_data` and `res_valid` hold and no pop occurs.
- **Push and pop in the same cycle** on one FIFO: both take effect and the level is unchanged.
- **Full FIFO:** `ready` is low, so no push is possible. There is no pass-through on full.
- **Empty FIFO:** there is no bypass. A pushed operand reaches the head only after the next edge.
- **Unpaired operands:** surplus operands on one side stay queued indefinitely. There is no timeout and no drop.
- **Pointer wrap:** read and write pointers are $clog2(DEPTH)+1 bits.
  - full = MSBs differ and the lower bits are equal.
  - empty = pointers equal.
  - Wrap-around must be seamless across arbitrarily many passes.
- **Arithmetic:** `res_data` is the adder output truncated to DATA_WIDTH (modulo 2^DATA_WIDTH). This block does no arithmetic of its own except with `ADD_OPERAND_CARRY_EN`.

## Timing

- **Reset:** the asynchronous assertion of `rst_n` immediately clears all pointers and sets the following outputs:

  | Output | Reset value |
  |---|---|
  | `res_valid` | 0 |
  | `res_data` | 0 |
  | `res_carry` | 0 |
  | `a_level`, `b_level` | 0 |
  | `a_ready`, `b_ready` | 0 |

  - `a_ready` and `b_ready` rise combinationally once `rst_n` deasserts.
  - Reset mid-operation discards all queued operands and any pending result. No partial result is ever presented.
- **Latency:** if the last operand of a pair is accepted on edge k and the output is free, `res_valid` is high after edge k+1. Minimum latency is 2 cycles from presenting that operand.
- **Throughput:** one result per cycle when both streams are valid every cycle and `res_ready` is held high.
- **Output stability:** `res_valid` and `res_data` are registers only. There is no combinational path from any input to `res_valid` or `res_data`.
- **Ready paths:** `a_ready` and `b_ready` depend only on registered state and `rst_n`.

## Configuration

- **`ADD_OPERAND_CARRY_EN` defined:**
  - On fire, `res_carry <= ({1'b0,add_a} + {1'b0,add_b})[DATA_WIDTH]`.
  - `res_carry` is registered with the same enable as `res_data`.
  - It holds during a stall and resets to 0.
- **`ADD_OPERAND_CARRY_EN` undefined:**
  - The `res_carry` port and its logic are absent.
  - All other behaviour is identical.

## Test plan

- **Single pair:** after reset, push a=5, b=7 in the same cycle with `res_ready`=1. Expect `res_valid` for exactly 1 cycle with `res_data`=12, 2 cycles after the push.
- **Wrap and carry:** push a=0xFFFF_FFFF, b=0x0000_0002. Expect `res_data`=0x0000_0001, and `res_carry`=1 when the macro is defined.
- **Skewed streams:** push 4 `src1` values (1, 2, 3, 4) with no `src2`.
  - Expect `a_level`=4, `a_ready`=0, and `res_valid`=0.
  - Then push `src2` values 10, 20, 30, 40. Expect results 11, 22, 33, 44 in order, on consecutive cycles.
- **Backpressure:** hold `res_ready`=0 while streaming pairs. Expect:
  - `res_data` held at the first sum;
  - both FIFOs filling to DEPTH, then both readies dropping to 0;
  - on release, every queued sum delivered once, in order, with no loss or duplication.
- **Mid-operation reset:** assert `rst_n`=0 asynchronously with both FIFOs at level 3 and `res_valid`=1.
  - Expect all outputs at their reset values immediately.
  - After release, a fresh pair a=1, b=1 yields `res_data`=2 with no stale result in between.
- **Long random run:** 10,000 random pairs with random valids and random `res_ready`, compared against a scoreboard of (a+b) mod 2^32. Expect zero mismatches, and pointer wrap exercised more than 1000 times.
